gl3_frame_seq: RTL and testbench

Frame sequencer placed in front of the 2x2 decimation stage on the AXI-stream video path. It locks onto start-of-frame (tuser) and forwards only whole frames. It starts and stops at frame boundaries under software control and checks line/frame geometry against configured dimensions. It adds zero latency: data and sideband pass combinationally, and only the valid/ready gating is sequential.

---
 rtl/gl3_frame_seq.sv | 197 +++++++++++++++++++
 tb/tb_gl3_frame_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gl3_frame_seq.sv
// Frame sequencer: locks onto SOF (tuser), forwards whole frames only, checks line/frame geometry.
// Latency: zero; data/tlast/tuser pass combinationally, only the valid/ready gating is stateful.
// Backpressure: down_ready passes straight to up_ready while forwarding; non-SOF beats are sunk while hunting.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   cfg_enable, cfg_oneshot   run request / stop after one frame (sampled at frame boundaries)
//   cfg_width, cfg_height     frame geometry, latched on each accepted SOF beat
//   err_clear                 clears the sticky error flags
//   up_*                      upstream AXI-stream (data, valid, ready, tlast = EOL, tuser = SOF)
//   down_*                    downstream AXI-stream, same sideband meaning
//   busy                      sequencer not idle
//   frame_done                one-cycle pulse after the last beat of a complete frame
//   err_short/err_long/err_sof sticky geometry errors
//   frame_count               completed frames, wraps
module gl3_frame_seq #(
  parameter int D_WIDTH = 8,
  parameter int W_BITS  = 12,
  parameter int H_BITS  = 12,
  parameter int FC_BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_enable,
  input  logic               cfg_oneshot,
  input  logic [W_BITS-1:0]  cfg_width,
  input  logic [H_BITS-1:0]  cfg_height,
  input  logic               err_clear,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               err_short,
  output logic               err_long,
  output logic               err_sof,
  output logic [FC_BITS-1:0] frame_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [W_BITS-1:0] width_q;
  logic [H_BITS-1:0] height_q;
  logic [W_BITS-1:0] pix_cnt;
  logic [H_BITS-1:0] line_cnt;

  logic              beat;
  logic              in_active;
  logic              in_wait;
  logic              mid_frame;
  logic              sof_start;
  logic              proc;
  logic [W_BITS-1:0] base_pix;
  logic [H_BITS-1:0] base_line;
  logic [W_BITS-1:0] eff_w;
  logic [H_BITS-1:0] eff_h;
  logic [W_BITS-1:0] pix_inc;
  logic [H_BITS-1:0] line_inc;
  logic              set_short;
  logic              set_long;
  logic              set_sof;
  logic              eof;
  logic              next_run;

  assign down_data  = up_data;
  assign down_tlast = up_tlast;
  assign down_tuser = up_tuser;
  assign busy       = (state != S_IDLE);

  // Handshake gating. While hunting, only a SOF beat is offered downstream;
  // anything else is accepted and discarded so the upstream keeps moving.
  always_comb begin
    up_ready   = 1'b0;
    down_valid = 1'b0;
    case (state)
      S_WAIT_SOF: begin
        if (up_tuser) begin
          down_valid = up_valid;
          up_ready   = down_ready;
        end else begin
          up_ready   = 1'b1;
        end
      end
      S_ACTIVE: begin
        down_valid = up_valid;
        up_ready   = down_ready;
      end
      default: begin
        up_ready   = 1'b0;
        down_valid = 1'b0;
      end
    endcase
  end

  assign beat      = up_valid & up_ready;
  assign in_active = (state == S_ACTIVE);
  assign in_wait   = (state == S_WAIT_SOF);
  assign mid_frame = (pix_cnt != '0) | (line_cnt != '0);

  // A SOF beat either opens a frame from WAIT_SOF or restarts a frame in ACTIVE.
  // Both paths then run the ordinary per-beat rules from a zero position with
  // the freshly latched geometry, which also covers a SOF beat that carries tlast.
  assign sof_start = beat & up_tuser & (in_wait | (in_active & mid_frame));
  assign set_sof   = beat & up_tuser & in_active & mid_frame;
  assign proc      = beat & (in_active | sof_start);

  assign base_pix  = sof_start ? '0 : pix_cnt;
  assign base_line = sof_start ? '0 : line_cnt;
  assign eff_w     = sof_start ? cfg_width  : width_q;
  assign eff_h     = sof_start ? cfg_height : height_q;

  // Pixel counter saturates so an overlong line cannot wrap into a false match.
  assign pix_inc   = (&base_pix) ? base_pix : base_pix + 1'b1;
  assign line_inc  = base_line + 1'b1;

  assign set_short = proc &  up_tlast & (pix_inc <  eff_w);
  assign set_long  = proc & ~up_tlast & (pix_inc == eff_w);
  assign eof       = proc &  up_tlast & (line_inc == eff_h);
  assign next_run  = cfg_enable & ~cfg_oneshot;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cfg_enable && (cfg_width != '0) && (cfg_height != '0)) begin
          state_nxt = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        // An accepted SOF has already been forwarded, so it wins over a falling enable.
        if (eof) begin
          state_nxt = next_run ? S_WAIT_SOF : S_IDLE;
        end else if (proc) begin
          state_nxt = S_ACTIVE;
        end else if (!cfg_enable) begin
          state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (eof) begin
          state_nxt = next_run ? S_WAIT_SOF : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_sof     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sof_start) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
      end
      if (proc) begin
        if (up_tlast) begin
          pix_cnt  <= '0;
          line_cnt <= eof ? '0 : line_inc;
        end else begin
          pix_cnt  <= pix_inc;
          line_cnt <= base_line;
        end
      end
      frame_done <= eof;
      if (eof) begin
        frame_count <= frame_count + 1'b1;
      end
      // A new error in the same cycle as a clear stays visible.
      err_short <= set_short | (err_short & ~err_clear);
      err_long  <= set_long  | (err_long  & ~err_clear);
      err_sof   <= set_sof   | (err_sof   & ~err_clear);
    end
  end

endmodule

// File: tb/tb_gl3_frame_seq.sv
module tb_gl3_frame_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable, cfg_oneshot, err_clear;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [7:0]  up_data;
  logic        up_valid, up_tlast, up_tuser, up_ready;
  logic [7:0]  down_data;
  logic        down_valid, down_tlast, down_tuser, down_ready;
  logic        busy, frame_done, err_short, err_long, err_sof;
  logic [15:0] frame_count;

  gl3_frame_seq dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .err_clear(err_clear),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_ready(up_ready),
    .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
    .down_tuser(down_tuser), .down_ready(down_ready),
    .busy(busy), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .err_sof(err_sof),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t stim[$];
  beat_t want[$];
  beat_t got[$];

  int checks = 0;
  int errors = 0;
  int clr_pct = 0;
  int drop_en_at = -1;
  int acc_cnt = 0;
  int done_pulses = 0;

  // Reference model: 0 = stopped, 1 = hunting for SOF, 2 = inside a frame.
  int m_mode, m_px, m_ln, m_w, m_h, m_fc;
  bit m_es, m_el, m_ef, m_done;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_px = 0; m_ln = 0; m_w = 0; m_h = 0; m_fc = 0;
    m_es = 0; m_el = 0; m_ef = 0; m_done = 0;
  endtask

  task automatic model_hs(output bit rdy, output bit dv);
    rdy = 0; dv = 0;
    if (m_mode == 1) begin
      if (up_tuser) begin dv = up_valid; rdy = down_ready; end
      else rdy = 1;
    end else if (m_mode == 2) begin
      dv = up_valid; rdy = down_ready;
    end
  endtask

  task automatic model_step(input bit beat);
    bit nd = 0;
    bit restart;
    int p0, l0;
    if (err_clear) begin m_es = 0; m_el = 0; m_ef = 0; end
    if (m_mode == 0) begin
      if (cfg_enable && cfg_width != 0 && cfg_height != 0) m_mode = 1;
    end else begin
      restart = beat && up_tuser && (m_mode == 1 || m_px != 0 || m_ln != 0);
      if (restart) begin
        if (m_mode == 2) m_ef = 1;
        m_w = int'(cfg_width); m_h = int'(cfg_height); p0 = 0; l0 = 0;
      end else begin
        p0 = m_px; l0 = m_ln;
      end
      if (beat && (restart || m_mode == 2)) begin
        m_mode = 2;
        if (up_tlast) begin
          if (p0 + 1 < m_w) m_es = 1;
          m_px = 0;
          m_ln = l0 + 1;
          if (m_ln == m_h) begin
            nd = 1;
            m_fc = (m_fc + 1) % 65536;
            m_ln = 0;
            m_mode = (cfg_enable && !cfg_oneshot) ? 1 : 0;
          end
        end else begin
          m_px = p0 + 1;
          m_ln = l0;
          if (m_px == m_w) m_el = 1;
        end
      end else if (m_mode == 1 && !cfg_enable) begin
        m_mode = 0;
      end
    end
    m_done = nd;
  endtask

  // One clock: drive after the edge, check at negedge, step the model, advance.
  task automatic cycle(input int vld_pct, input int rdy_pct);
    bit rdy, dv;
    beat_t b;
    err_clear  = ($urandom_range(99) < clr_pct);
    down_ready = ($urandom_range(99) < rdy_pct);
    if (stim.size() != 0) begin
      up_valid = ($urandom_range(99) < vld_pct);
      up_data = stim[0].d; up_tlast = stim[0].l; up_tuser = stim[0].u;
    end else begin
      up_valid = 1'b0;
      up_data = 8'($urandom); up_tlast = 1'b0; up_tuser = 1'b0;
    end
    @(negedge clk);
    model_hs(rdy, dv);
    check_val("up_ready", up_ready, rdy);
    check_val("down_valid", down_valid, dv);
    check_val("busy", busy, m_mode != 0);
    check_val("frame_done", frame_done, m_done);
    check_val("err_short", err_short, m_es);
    check_val("err_long", err_long, m_el);
    check_val("err_sof", err_sof, m_ef);
    check_val("frame_count", frame_count, m_fc);
    if (frame_done) done_pulses++;
    if (down_valid && down_ready) begin
      b.d = down_data; b.l = down_tlast; b.u = down_tuser;
      got.push_back(b);
    end
    model_step(up_valid && rdy);
    if (up_valid && rdy) begin
      void'(stim.pop_front());
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (drop_en_at >= 0 && acc_cnt >= drop_en_at) cfg_enable = 1'b0;
  endtask

  task automatic run(input int n, input int vld_pct, input int rdy_pct);
    for (int i = 0; i < n; i++) cycle(vld_pct, rdy_pct);
  endtask

  task automatic run_until_empty(input int budget, input int vld_pct, input int rdy_pct);
    int k = 0;
    while (stim.size() != 0 && k < budget) begin
      cycle(vld_pct, rdy_pct);
      k++;
    end
    check_val("drain", stim.size(), 0);
  endtask

  task automatic push_line(input int n, input bit sof, input bit eol, input bit to_want);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = 8'($urandom);
      b.u = sof && (i == 0);
      b.l = eol && (i == n - 1);
      stim.push_back(b);
      if (to_want) want.push_back(b);
    end
  endtask

  task automatic push_frame(input int w, input int h, input bit to_want);
    for (int ln = 0; ln < h; ln++) push_line(w, ln == 0, 1'b1, to_want);
  endtask

  task automatic compare_lists();
    check_val("fwd_count", got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++)
      check_val("fwd_beat", {got[i].d, got[i].l, got[i].u}, {want[i].d, want[i].l, want[i].u});
    got.delete();
    want.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, fc0, junk, len;
    // Reset state, with inputs that would otherwise open the handshake.
    rst = 1'b0;
    cfg_enable = 1'b1; cfg_oneshot = 1'b0; err_clear = 1'b0;
    cfg_width = 12'd4; cfg_height = 12'd2;
    up_valid = 1'b1; up_tuser = 1'b1; up_tlast = 1'b0; up_data = 8'h5a; down_ready = 1'b1;
    model_reset();
    #3;
    check_val("rst_up_ready", up_ready, 0);
    check_val("rst_down_valid", down_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_count", frame_count, 0);
    check_val("rst_flags", {frame_done, err_short, err_long, err_sof}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Junk before SOF, then a clean 4x2 frame.
    push_line(3, 1'b0, 1'b0, 1'b0);
    push_frame(4, 2, 1'b1);
    done_pulses = 0;
    run_until_empty(200, 100, 100);
    run(3, 100, 100);
    compare_lists();
    check_val("a_done_pulses", done_pulses, 1);
    check_val("a_frame_count", frame_count, 1);
    check_val("a_errors", {err_short, err_long, err_sof}, 0);

    // One-shot: first frame only; software drops enable during that frame.
    cfg_oneshot = 1'b1;
    push_frame(4, 2, 1'b1);
    push_frame(4, 2, 1'b0);
    drop_en_at = acc_cnt + 2;
    done_pulses = 0;
    run(40, 100, 100);
    compare_lists();
    check_val("b_done_pulses", done_pulses, 1);
    check_val("b_busy", busy, 0);
    check_val("b_up_ready", up_ready, 0);
    stim.delete();
    drop_en_at = -1;
    cfg_oneshot = 1'b0;
    cfg_enable = 1'b1;

    // Short line, clear, then long line.
    push_line(3, 1'b1, 1'b1, 1'b1);
    push_line(4, 1'b0, 1'b1, 1'b1);
    run_until_empty(200, 100, 100);
    run(2, 100, 100);
    check_val("c_err_short_sticky", err_short, 1);
    clr_pct = 100; run(1, 100, 100); clr_pct = 0;
    run(1, 100, 100);
    check_val("c_err_short_cleared", err_short, 0);
    push_line(5, 1'b1, 1'b1, 1'b1);
    push_line(4, 1'b0, 1'b1, 1'b1);
    run_until_empty(200, 100, 100);
    run(2, 100, 100);
    check_val("c_err_long", err_long, 1);
    check_val("c_err_short_still_clear", err_short, 0);
    compare_lists();

    // SOF mid-frame: aborted frame not counted, restarted frame is.
    clr_pct = 100; run(1, 100, 100); clr_pct = 0;
    fc0 = m_fc;
    push_line(2, 1'b1, 1'b0, 1'b1);
    push_frame(4, 2, 1'b1);
    done_pulses = 0;
    run_until_empty(200, 100, 100);
    run(2, 100, 100);
    check_val("d_err_sof", err_sof, 1);
    check_val("d_done_pulses", done_pulses, 1);
    check_val("d_frame_count", frame_count, (fc0 + 1) % 65536);
    compare_lists();

    // Random downstream backpressure on one frame.
    acc0 = acc_cnt;
    done_pulses = 0;
    push_frame(4, 2, 1'b1);
    run_until_empty(400, 70, 50);
    run(3, 100, 100);
    compare_lists();
    check_val("e_accepted", acc_cnt - acc0, 8);
    check_val("e_done_pulses", done_pulses, 1);

    // Randomised frames with geometry faults, junk, one-shot and clears.
    clr_pct = 3;
    for (int f = 0; f < 24; f++) begin
      cfg_width   = 12'($urandom_range(6, 2));
      cfg_height  = 12'($urandom_range(3, 1));
      cfg_oneshot = ($urandom_range(3) == 0);
      junk = $urandom_range(2);
      if (junk != 0) push_line(junk, 1'b0, 1'b1, 1'b0);
      for (int ln = 0; ln < int'(cfg_height); ln++) begin
        len = int'(cfg_width);
        if ($urandom_range(3) == 0) len = len + $urandom_range(2) - 1;
        push_line(len, ln == 0, 1'b1, 1'b0);
      end
      run_until_empty(600, 80, 60);
    end
    clr_pct = 0;
    cfg_oneshot = 1'b0;
    run(5, 100, 100);
    got.delete();
    want.delete();

    // Asynchronous reset mid-frame; remainder must be dropped until the next SOF.
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_enable = 1'b1;
    run(3, 100, 100);
    push_line(3, 1'b1, 1'b1, 1'b0);
    push_line(2, 1'b0, 1'b0, 1'b0);
    run_until_empty(200, 100, 100);
    check_val("g_pre_busy", busy, 1);
    up_valid = 1'b1; up_tuser = 1'b0; up_tlast = 1'b0; down_ready = 1'b1; err_clear = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_val("g_rst_up_ready", up_ready, 0);
    check_val("g_rst_down_valid", down_valid, 0);
    check_val("g_rst_busy", busy, 0);
    check_val("g_rst_flags", {err_short, err_long, err_sof}, 0);
    check_val("g_rst_frame_count", frame_count, 0);
    model_reset();
    #1;
    rst = 1'b1;
    got.delete();
    done_pulses = 0;
    push_line(2, 1'b0, 1'b1, 1'b0);
    push_frame(4, 2, 1'b1);
    run_until_empty(200, 100, 100);
    run(3, 100, 100);
    compare_lists();
    check_val("g_done_pulses", done_pulses, 1);
    check_val("g_frame_count", frame_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
